// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: stall/flush/forward generation,
// post-reset boot flush, external-busy freeze with timeout, saturating perf counters.
module hazard_ctrl #(
    parameter int BOOT_CYCLES = 3,
    parameter int MAX_HOLD    = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       rs1_d_i,
    input  logic [4:0]       rs2_d_i,
    input  logic [4:0]       rs1_e_i,
    input  logic [4:0]       rs2_e_i,
    input  logic [4:0]       rd_e_i,
    input  logic             load_e_i,
    input  logic             pcsrc_e_i,
    input  logic             regwrite_m_i,
    input  logic [4:0]       rd_m_i,
    input  logic             regwrite_w_i,
    input  logic [4:0]       rd_w_i,
    input  logic             ext_busy_i,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic [1:0]       forward_ae_o,
    output logic [1:0]       forward_be_o,
    output logic             hold_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu;
    logic stall_f, stall_d, stall_e, flush_d, flush_e;

    // M-stage result is younger than W, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic we_m,
                                           input logic [4:0] rd_m, input logic we_w,
                                           input logic [4:0] rd_w);
        if (we_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
        else if (we_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
        else                                         return 2'b00;
    endfunction

    assign lu = load_e_i && (rd_e_i != 5'd0) && (rd_e_i == rs1_d_i || rd_e_i == rs2_d_i);

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = timeout_q;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        case (state_q)
            S_BOOT: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = S_RUN;
                    boot_cnt_d = '0;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
            S_RUN, S_HOLD: begin
                if (ext_busy_i) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                end else if (pcsrc_e_i) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (lu) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
                state_d = ext_busy_i ? S_HOLD : S_RUN;
                if (state_q == S_RUN) begin
                    if (ext_busy_i) hold_cnt_d = '0;
                end else begin
                    if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_d == HOLD_MAX) timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_BOOT;
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_d && (state_q == S_RUN || state_q == S_HOLD) && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_BOOT;
            boot_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_f_o      = stall_f;
    assign stall_d_o      = stall_d;
    assign stall_e_o      = stall_e;
    assign flush_d_o      = flush_d;
    assign flush_e_o      = flush_e;
    // Forward selects are held at 00 while reset is asserted.
    assign forward_ae_o   = rst_ni ? fwd_sel(rs1_e_i, regwrite_m_i, rd_m_i, regwrite_w_i, rd_w_i) : 2'b00;
    assign forward_be_o   = rst_ni ? fwd_sel(rs2_e_i, regwrite_m_i, rd_m_i, regwrite_w_i, rd_w_i) : 2'b00;
    assign hold_timeout_o = timeout_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table through a scoreboard queue,
// plus hand sequences for boot, load-use, long freeze/timeout and async reset.
module tb_hazard_ctrl;

    localparam int CW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [4:0]    rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, rd_m_i, rd_w_i;
    logic          load_e_i, pcsrc_e_i, regwrite_m_i, regwrite_w_i, ext_busy_i;
    logic          stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o, hold_timeout_o;
    logic [1:0]    forward_ae_o, forward_be_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    hazard_ctrl #(.BOOT_CYCLES(3), .MAX_HOLD(255), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i), .rs1_e_i(rs1_e_i), .rs2_e_i(rs2_e_i),
        .rd_e_i(rd_e_i), .load_e_i(load_e_i), .pcsrc_e_i(pcsrc_e_i),
        .regwrite_m_i(regwrite_m_i), .rd_m_i(rd_m_i),
        .regwrite_w_i(regwrite_w_i), .rd_w_i(rd_w_i), .ext_busy_i(ext_busy_i),
        .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .stall_e_o(stall_e_o),
        .flush_d_o(flush_d_o), .flush_e_o(flush_e_o),
        .forward_ae_o(forward_ae_o), .forward_be_o(forward_be_o),
        .hold_timeout_o(hold_timeout_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // exp packs {stall_f, stall_d, stall_e, flush_d, flush_e, fwd_a[1:0], fwd_b[1:0]}
    typedef struct {
        string      name;
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic       load_e, pcsrc_e, we_m;
        logic [4:0] rd_m;
        logic       we_w;
        logic [4:0] rd_w;
        logic       busy;
        logic [8:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } sb_t;

    sb_t  sbq[$];
    vec_t tbl[14];
    int   total = 0;
    int   bad   = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    wire [8:0] outs = {stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o,
                       forward_ae_o, forward_be_o};

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs1_d_i = v.rs1_d; rs2_d_i = v.rs2_d; rs1_e_i = v.rs1_e; rs2_e_i = v.rs2_e;
        rd_e_i = v.rd_e; load_e_i = v.load_e; pcsrc_e_i = v.pcsrc_e;
        regwrite_m_i = v.we_m; rd_m_i = v.rd_m; regwrite_w_i = v.we_w; rd_w_i = v.rd_w;
        ext_busy_i = v.busy;
    endtask

    // Drive one cycle (called just after a rising edge), compare at the falling edge.
    task automatic step(input vec_t v, input bit counted);
        sb_t s;
        drive(v);
        sbq.push_back('{v.name, v.exp});
        if (counted && v.exp[8]) exp_stall = sat(exp_stall);
        if (counted && v.exp[5]) exp_flush = sat(exp_flush);
        @(negedge clk_i);
        if (sbq.size() == 0) chk("scoreboard_empty", 1, 0);
        else begin
            s = sbq.pop_front();
            chk(s.name, int'(outs), int'(s.exp));
        end
        @(posedge clk_i);
        #1;
    endtask

    vec_t idle, v;

    initial begin
        idle = '{"idle", 0,0,0,0,0, 0,0,0, 0, 0, 0, 0, 9'b00000_00_00};
        //        name        rs1d rs2d rs1e rs2e rde ld br wm rdm ww rdw bsy exp
        tbl[0]  = '{"idle",     0, 0, 0, 0, 0, 0,0,0, 0,0, 0,0, 9'b00000_00_00};
        tbl[1]  = '{"fwd_mm",   0, 0, 7, 7, 0, 0,0,1, 7,1, 7,0, 9'b00000_10_10};
        tbl[2]  = '{"fwd_m0",   0, 0, 7, 0, 0, 0,0,1, 0,1, 7,0, 9'b00000_01_00};
        tbl[3]  = '{"fwd_mix",  0, 0, 4, 3, 0, 0,0,1, 4,1, 3,0, 9'b00000_10_01};
        tbl[4]  = '{"fwd_nowe", 0, 0, 7, 7, 0, 0,0,0, 7,0, 7,0, 9'b00000_00_00};
        tbl[5]  = '{"lu_rs1",   5, 1, 0, 0, 5, 1,0,0, 0,0, 0,0, 9'b11001_00_00};
        tbl[6]  = '{"lu_rs2",   2, 9, 0, 0, 9, 1,0,0, 0,0, 0,0, 9'b11001_00_00};
        tbl[7]  = '{"lu_x0",    0, 0, 0, 0, 0, 1,0,0, 0,0, 0,0, 9'b00000_00_00};
        tbl[8]  = '{"no_load",  5, 0, 0, 0, 5, 0,0,0, 0,0, 0,0, 9'b00000_00_00};
        tbl[9]  = '{"br_lu",    5, 0, 0, 0, 5, 1,1,0, 0,0, 0,0, 9'b00011_00_00};
        tbl[10] = '{"busy_all", 5, 0, 7, 0, 5, 1,1,1, 7,0, 0,1, 9'b11100_10_00};
        tbl[11] = '{"rel_br",   5, 0, 0, 0, 5, 1,1,0, 0,0, 0,0, 9'b00011_00_00};
        tbl[12] = '{"busy_lu",  5, 0, 0, 0, 5, 1,0,0, 0,0, 0,1, 9'b11100_00_00};
        tbl[13] = '{"rel_lu",   5, 0, 0, 0, 5, 1,0,0, 0,0, 0,0, 9'b11001_00_00};

        // Reset state, with inputs that would otherwise forward and stall
        rst_ni = 1'b0;
        v = '{"rst", 7,0,7,7,7, 1,1,1,7,1,7,1, 9'b0};
        drive(v);
        #12;
        chk("rst_outs", int'(outs), int'(9'b00011_00_00));
        chk("rst_stall_cnt", int'(stall_cnt_o), 0);
        chk("rst_flush_cnt", int'(flush_cnt_o), 0);
        chk("rst_timeout", int'(hold_timeout_o), 0);

        // Boot: three flush cycles regardless of busy/branch/load-use inputs
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v = '{$sformatf("boot%0d", i), 5,0,0,0,5, 1,1,0,0,0,0,1, 9'b00011_00_00};
            step(v, 1'b0);
        end
        chk("boot_flush_cnt", int'(flush_cnt_o), 0);

        for (int i = 0; i < 14; i++) step(tbl[i], 1'b1);
        chk("tbl_stall_cnt", int'(stall_cnt_o), exp_stall);
        chk("tbl_flush_cnt", int'(flush_cnt_o), exp_flush);

        // lw x5 ; add x6,x5,x1 -> one bubble, then W-path forward
        v = '{"lu_seq_a", 5,1,0,0,5, 1,0,0,0,0,0,0, 9'b11001_00_00};
        step(v, 1'b1);
        v = '{"lu_seq_b", 0,0,5,1,6, 0,0,0,0,1,5,0, 9'b00000_01_00};
        step(v, 1'b1);
        chk("lu_seq_stall_cnt", int'(stall_cnt_o), exp_stall);

        // 300-cycle freeze with a pending branch: timeout after 255 HOLD cycles
        for (int i = 0; i < 300; i++) begin
            v = '{"hold_long", 0,0,0,0,0, 0,1,0,0,0,0,1, 9'b11100_00_00};
            step(v, 1'b1);
            if (i == 254) chk("timeout_early", int'(hold_timeout_o), 0);
            if (i == 255) chk("timeout_set", int'(hold_timeout_o), 1);
        end
        v = '{"hold_rel_br", 0,0,0,0,0, 0,1,0,0,0,0,0, 9'b00011_00_00};
        step(v, 1'b1);
        chk("sat_stall_cnt", int'(stall_cnt_o), exp_stall);
        chk("hold_flush_cnt", int'(flush_cnt_o), exp_flush);
        chk("timeout_sticky", int'(hold_timeout_o), 1);
        step(idle, 1'b1);

        // Async reset in the middle of a freeze
        for (int i = 0; i < 3; i++) begin
            v = '{"hold_pre_rst", 0,0,7,0,0, 0,0,1,7,0,0,1, 9'b11100_10_00};
            step(v, 1'b1);
        end
        #2 rst_ni = 1'b0;
        #1;
        chk("midhold_rst_outs", int'(outs), int'(9'b00011_00_00));
        chk("midhold_rst_stall_cnt", int'(stall_cnt_o), 0);
        chk("midhold_rst_flush_cnt", int'(flush_cnt_o), 0);
        chk("midhold_rst_timeout", int'(hold_timeout_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
